// File: rtl/noc_packetizer_pkg.sv
// rtl/noc_packetizer_pkg.sv - shared NoC flit types and header construction helper
package noc_types;

  localparam int X_W        = 4;
  localparam int Y_W        = 4;
  localparam int DATA_W     = 32;
  localparam int TAIL_LEN_W = 4;
  localparam int TAG_W      = 8;
  localparam int RSVD_W     = DATA_W - X_W - Y_W - TAIL_LEN_W - TAG_W;

  // Largest payload a header can describe; default packet length limit.
  localparam int MAX_PKT_LEN = (1 << TAIL_LEN_W) - 1;

  // NONE marks an empty output slot (reset value); never sent as valid.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2,
    TAIL   = 2'd3
  } flit_type_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } addr_t;

  // Header payload layout, MSB first: dst.x, dst.y, tail_length, tag, reserved.
  typedef struct packed {
    addr_t                 dst;
    logic [TAIL_LEN_W-1:0] tail_length;
    logic [TAG_W-1:0]      tag;
    logic [RSVD_W-1:0]     rsvd;
  } flit_hdr_info;

  typedef struct packed {
    flit_type_e        ftype;
    logic [DATA_W-1:0] data;
  } flit_t;

endpackage

package noc_functions;

  import noc_types::*;

  // Every header flit in the NoC is assembled here so the layout lives in one place.
  function automatic flit_t build_header_info(
    input logic [X_W-1:0]        x,
    input logic [Y_W-1:0]        y,
    input logic [TAIL_LEN_W-1:0] len,
    input logic [TAG_W-1:0]      tag
  );
    flit_hdr_info info;
    flit_t        f;
    info             = '0;
    info.dst.x       = x;
    info.dst.y       = y;
    info.tail_length = len;
    info.tag         = tag;
    f.ftype          = HEADER;
    f.data           = info;
    return f;
  endfunction

endpackage

// File: rtl/noc_packetizer.sv
// rtl/noc_packetizer.sv - wormhole packet injection stage; optional counters via NOC_PACKETIZER_STATS_EN
module noc_packetizer
  import noc_types::*;
#(
  parameter int MAX_LEN = MAX_PKT_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  addr_t             cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output flit_t             out_flit
`ifdef NOC_PACKETIZER_STATS_EN
  ,
  output logic [31:0]       pkt_count,
  output logic [31:0]       flit_count
`endif
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PAYLOAD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             out_valid_q, out_valid_d;
  flit_t            out_flit_q, out_flit_d;
  logic             slot_free;

  // Next state: one output slot, reloaded only when empty or being drained this cycle.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q && !out_ready;
    out_flit_d  = out_flit_q;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    slot_free   = !out_valid_q || out_ready;

    case (state_q)
      S_IDLE: begin
        cmd_ready = slot_free && !rst;
        if (cmd_valid && cmd_ready) begin
          out_flit_d  = noc_functions::build_header_info(cmd_dst.x, cmd_dst.y,
                                                         TAIL_LEN_W'(cmd_len), '0);
          out_valid_d = 1'b1;
          rem_d       = cmd_len;
          // A zero-length command is a header-only packet; stay ready for the next one.
          if (cmd_len != '0) begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        in_ready = slot_free && !rst;
        if (in_valid && in_ready) begin
          out_flit_d.ftype = (rem_q > LEN_W'(1)) ? BODY : TAIL;
          out_flit_d.data  = in_data;
          out_valid_d      = 1'b1;
          rem_d            = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, remaining-word counter and output slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;

`ifdef NOC_PACKETIZER_STATS_EN
  logic [31:0] pkt_count_q, flit_count_q;

  // Count packets (by their header) and flits as they leave on the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q  <= '0;
      flit_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      flit_count_q <= flit_count_q + 32'd1;
      if (out_flit_q.ftype == HEADER) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
    end
  end

  assign pkt_count  = pkt_count_q;
  assign flit_count = flit_count_q;
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
// tb/tb_noc_packetizer.sv - self-checking bench for noc_packetizer (stats checks with NOC_PACKETIZER_STATS_EN)
module tb_noc_packetizer;

  import noc_types::*;

  localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  addr_t             cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  flit_t             out_flit;
  logic [33:0]       out_bits;
`ifdef NOC_PACKETIZER_STATS_EN
  logic [31:0]       pkt_count;
  logic [31:0]       flit_count;
`endif

  noc_packetizer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flit  (out_flit)
`ifdef NOC_PACKETIZER_STATS_EN
    ,
    .pkt_count (pkt_count),
    .flit_count(flit_count)
`endif
  );

  assign out_bits = out_flit;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the one-flit output slot plus the words still owed to the open packet.
  logic        m_valid;
  logic [33:0] m_flit;
  int          owed;

  typedef struct {
    int          x;
    int          y;
    int          len;
    logic [31:0] hdr;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Header word from the field layout: x[31:28] y[27:24] tail_length[23:20], tag 0.
  function automatic logic [33:0] exp_header(input int x, input int y, input int len);
    logic [31:0] w;
    w = 32'(x) * 32'h1000_0000 + 32'(y) * 32'h0100_0000 + 32'(len) * 32'h0010_0000;
    return {2'd1, w};
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Sample at the falling edge, compare against the model, then advance the model
  // by the handshakes that the coming rising edge will perform.
  task automatic sample();
    logic free, e_cmd, e_in;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) chk("out_flit", 64'(out_bits), 64'(m_flit));
    free  = !m_valid || out_ready;
    e_cmd = !rst && (owed == 0) && free;
    e_in  = !rst && (owed != 0) && free;
    chk("cmd_ready", 64'(cmd_ready), 64'(e_cmd));
    chk("in_ready", 64'(in_ready), 64'(e_in));
    if (rst) begin
      m_valid = 1'b0;
      owed    = 0;
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (cmd_valid && e_cmd) begin
        m_flit  = exp_header(int'(cmd_dst.x), int'(cmd_dst.y), int'(cmd_len));
        m_valid = 1'b1;
        owed    = int'(cmd_len);
      end else if (in_valid && e_in) begin
        m_flit  = {(owed > 1) ? 2'd2 : 2'd3, in_data};
        m_valid = 1'b1;
        owed    = owed - 1;
      end
    end
  endtask

  // Send one packet with out_ready high; flits must follow on consecutive cycles.
  task automatic run_pkt(input int x, input int y, input int len, input logic [31:0] hdr);
    logic [31:0] d[16];
    int n;
    for (int i = 0; i < 16; i++) d[i] = $urandom;
    cmd_valid = 1'b1;
    cmd_dst   = '{x: 4'(x), y: 4'(y)};
    cmd_len   = LEN_W'(len);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    sample();
    while (!cmd_ready && n < 20) begin
      adv();
      sample();
      n++;
    end
    chk("pkt_cmd_accept", 64'(cmd_ready), 64'(1));
    adv();
    cmd_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      in_valid = (k < len);
      in_data  = (k < len) ? d[k] : 32'd0;
      sample();
      chk("pkt_out_valid", 64'(out_valid), 64'(1));
      if (k == 0) chk("pkt_header", 64'(out_bits), 64'({2'd1, hdr}));
      else        chk("pkt_payload", 64'(out_bits), 64'({(k < len) ? 2'd2 : 2'd3, d[k-1]}));
      adv();
    end
    in_valid = 1'b0;
    sample();
    chk("pkt_end_valid", 64'(out_valid), 64'(0));
    chk("pkt_end_cmd_ready", 64'(cmd_ready), 64'(1));
    adv();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{2, 1, 3, 32'h2130_0000};
    tbl[1] = '{0, 0, 0, 32'h0000_0000};
    tbl[2] = '{5, 10, 1, 32'h5A10_0000};
    tbl[3] = '{15, 15, 15, 32'hFFF0_0000};
    tbl[4] = '{3, 7, 2, 32'h3720_0000};

    m_valid = 1'b0;
    m_flit  = '0;
    owed    = 0;

    // Reset with a command and a word offered: neither may be taken.
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_dst   = '{x: 4'd1, y: 4'd1};
    cmd_len   = LEN_W'(1);
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    adv();
    adv();
    sample();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_flit", 64'(out_bits), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    adv();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    sample();
    chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("idle_in_ready", 64'(in_ready), 64'(0));
    adv();

`ifdef NOC_PACKETIZER_STATS_EN
    run_pkt(1, 2, 0, 32'h1200_0000);
    run_pkt(2, 3, 2, 32'h2320_0000);
    run_pkt(4, 5, 15, 32'h45F0_0000);
    sample();
    chk("stats_pkt_count", 64'(pkt_count), 64'(3));
    chk("stats_flit_count", 64'(flit_count), 64'(20));
    adv();
`endif

    for (int i = 0; i < 5; i++) run_pkt(tbl[i].x, tbl[i].y, tbl[i].len, tbl[i].hdr);

    // Header-only packet followed immediately by another command.
    cmd_valid = 1'b1;
    cmd_dst   = '{x: 4'd4, y: 4'd4};
    cmd_len   = LEN_W'(0);
    sample();
    chk("len0_accept", 64'(cmd_ready), 64'(1));
    adv();
    cmd_dst = '{x: 4'd6, y: 4'd2};
    sample();
    chk("len0_hdr1", 64'(out_bits), 64'({2'd1, 32'h4400_0000}));
    chk("len0_next_ready", 64'(cmd_ready), 64'(1));
    adv();
    cmd_valid = 1'b0;
    sample();
    chk("len0_hdr2", 64'(out_bits), 64'({2'd1, 32'h6200_0000}));
    adv();

    // Two len-1 packets back to back with data always offered.
    cmd_valid = 1'b1;
    cmd_dst   = '{x: 4'd1, y: 4'd2};
    cmd_len   = LEN_W'(1);
    in_valid  = 1'b0;
    sample();
    adv();
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_0001;
    sample();
    chk("b2b_hdr_a", 64'(out_bits), 64'({2'd1, 32'h1210_0000}));
    adv();
    cmd_valid = 1'b1;
    cmd_dst   = '{x: 4'd3, y: 4'd4};
    in_data   = 32'hBBBB_0002;
    sample();
    chk("b2b_tail_a", 64'(out_bits), 64'({2'd3, 32'hAAAA_0001}));
    chk("b2b_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("b2b_idle_in_ready", 64'(in_ready), 64'(0));
    adv();
    cmd_valid = 1'b0;
    sample();
    chk("b2b_hdr_b", 64'(out_bits), 64'({2'd1, 32'h3410_0000}));
    adv();
    in_valid = 1'b0;
    sample();
    chk("b2b_tail_b", 64'(out_bits), 64'({2'd3, 32'hBBBB_0002}));
    chk("b2b_tail_b_valid", 64'(out_valid), 64'(1));
    adv();

    // len 2 with the downstream stalled for five cycles after the header.
    cmd_valid = 1'b1;
    cmd_dst   = '{x: 4'd7, y: 4'd1};
    cmd_len   = LEN_W'(2);
    sample();
    adv();
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD000_0000;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("stall_flit", 64'(out_bits), 64'({2'd1, 32'h7120_0000}));
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      adv();
    end
    out_ready = 1'b1;
    sample();
    chk("stall_release_in_ready", 64'(in_ready), 64'(1));
    adv();
    in_data = 32'hD000_0001;
    sample();
    chk("stall_body", 64'(out_bits), 64'({2'd2, 32'hD000_0000}));
    adv();
    in_valid = 1'b0;
    sample();
    chk("stall_tail", 64'(out_bits), 64'({2'd3, 32'hD000_0001}));
    adv();

    // Reset after the first BODY of a len-4 packet.
    cmd_valid = 1'b1;
    cmd_dst   = '{x: 4'd9, y: 4'd9};
    cmd_len   = LEN_W'(4);
    sample();
    adv();
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hE000_0000;
    sample();
    adv();
    rst     = 1'b1;
    in_data = 32'hE000_0001;
    sample();
    chk("rstmid_body", 64'(out_bits), 64'({2'd2, 32'hE000_0000}));
    adv();
    rst = 1'b0;
    sample();
    chk("rstmid_out_valid", 64'(out_valid), 64'(0));
    chk("rstmid_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rstmid_in_ready", 64'(in_ready), 64'(0));
    adv();
    in_valid = 1'b0;

    // Randomized traffic checked by the model on every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_dst   = '{x: 4'($urandom), y: 4'($urandom)};
      cmd_len   = LEN_W'($urandom_range(0, MAX_PKT_LEN));
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      sample();
      adv();
    end

    rst       = 1'b0;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    n = 0;
    while ((owed != 0 || m_valid) && n < 100) begin
      in_data = $urandom;
      sample();
      adv();
      n++;
    end
    in_valid = 1'b0;
    sample();
    chk("drain_out_valid", 64'(out_valid), 64'(0));
    chk("drain_cmd_ready", 64'(cmd_ready), 64'(1));
    adv();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
